// File: rtl/comb_sweep_pkg.sv
// Shared definitions for the combinational-implementation sweep checker.
//   state_e    : sequencer states
//   *_DEF      : default vector width, implementation count and settle time
//   all_equal  : true when the low n bits of y are all zeros or all ones
package comb_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned N_IN_DEF   = 4;
  localparam int unsigned N_IMPL_DEF = 4;
  localparam int unsigned SETTLE_DEF = 1;

  function automatic logic all_equal(input logic [31:0] y, input int unsigned n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return ((y & mask) == '0) || ((y & mask) == mask);
  endfunction

endpackage

// File: rtl/comb_sweep_check.sv
// Mismatch detector, error counter and first-failure capture.
// Ports:
//   clk_i            : clock, rising edge
//   rst_ni           : synchronous active-low reset
//   clear_i          : zero the counter and capture registers
//   en_i             : sample y_i for the vector vec_i this cycle
//   vec_i [N_IN]     : vector currently driven
//   y_i [N_IMPL]     : implementation outputs
//   err_cnt_o        : number of mismatching vectors
//   fail_valid_o     : capture registers hold data
//   first_fail_vec_o : vector of the first mismatch
//   first_fail_y_o   : implementation outputs at the first mismatch
module comb_sweep_check
  import comb_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned N_IMPL = N_IMPL_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [N_IN-1:0]   vec_i,
  input  logic [N_IMPL-1:0] y_i,
  output logic [N_IN:0]     err_cnt_o,
  output logic              fail_valid_o,
  output logic [N_IN-1:0]   first_fail_vec_o,
  output logic [N_IMPL-1:0] first_fail_y_o
);

  logic              mismatch;
  logic [N_IN:0]     err_cnt_q;
  logic              fail_valid_q;
  logic [N_IN-1:0]   ff_vec_q;
  logic [N_IMPL-1:0] ff_y_q;

  assign mismatch = ~all_equal(32'(y_i), N_IMPL);

  // err_cnt holds at most 2**N_IN, which fits in N_IN+1 bits without wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      ff_vec_q     <= '0;
      ff_y_q       <= '0;
    end else if (en_i && mismatch) begin
      err_cnt_q <= err_cnt_q + {{N_IN{1'b0}}, 1'b1};
      if (!fail_valid_q) begin
        fail_valid_q <= 1'b1;
        ff_vec_q     <= vec_i;
        ff_y_q       <= y_i;
      end
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign fail_valid_o     = fail_valid_q;
  assign first_fail_vec_o = ff_vec_q;
  assign first_fail_y_o   = ff_y_q;

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Self-check sequencer: sweeps every input vector into all implementations,
// waits SETTLE cycles per vector, then compares their outputs.
// Ports:
//   clk, rst_n      : clock and synchronous active-low reset
//   start           : begin a sweep (accepted in IDLE only)
//   abort           : cancel a running sweep
//   vec [N_IN]      : driven vector {A,B,C,D}, A is the MSB
//   y_in [N_IMPL]   : implementation outputs, bit i = implementation i
//   busy            : high in WAIT and CHECK
//   done            : one-cycle pulse after a completed sweep
//   pass            : last completed sweep had no mismatches
//   err_cnt         : number of mismatching vectors
//   fail_valid      : first-failure capture valid
//   first_fail_vec  : vector of the first mismatch
//   first_fail_y    : y_in captured at the first mismatch
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned N_IMPL = N_IMPL_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec,
  input  logic [N_IMPL-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [N_IMPL-1:0] first_fail_y
);

  localparam int unsigned    CW        = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  SETTLE_M1 = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_MAX  = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            chk_clear, chk_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    chk_clear = 1'b0;
    chk_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT;
          vec_d     = '0;
          cnt_d     = SETTLE_M1;
          pass_d    = 1'b0;
          chk_clear = 1'b1;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CHECK: begin
        // An aborted CHECK never enables the checker, so its sample is dropped.
        if (abort) begin
          state_d = IDLE;
        end else begin
          chk_en = 1'b1;
          if (vec_q == VEC_MAX) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = SETTLE_M1;
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        // err_cnt is final here: the last CHECK updated it on the entry edge.
        pass_d  = (err_cnt == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  comb_sweep_check #(
    .N_IN   (N_IN),
    .N_IMPL (N_IMPL)
  ) u_check (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (chk_clear),
    .en_i             (chk_en),
    .vec_i            (vec_q),
    .y_i              (y_in),
    .err_cnt_o        (err_cnt),
    .fail_valid_o     (fail_valid),
    .first_fail_vec_o (first_fail_vec),
    .first_fail_y_o   (first_fail_y)
  );

  assign vec  = vec_q;
  assign busy = (state_q == WAIT) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule
